// File: rtl/buf_demux_rx_pkg.sv
// Shared definitions for the receive-side queue steering block: class codes,
// FSM states and the default admission threshold.
package buf_demux_rx_pkg;

    localparam int THRES_DEFAULT = 3;

    // Same encoding as the TX-side sel/SEND_* codes
    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_REQ  = 2'b01;
    localparam logic [1:0] CLS_MEM  = 2'b10;
    localparam logic [1:0] CLS_NET  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

endpackage

// File: rtl/buf_demux_rx_if.sv
// Receive beat stream, queue space inputs and the shared queue write bus.
// The master side drives beats and space; the slave side is the steering block.
interface buf_demux_rx_if #(
    parameter int DW = 64
);
    logic [DW-1:0]   s_tdata;
    logic [DW/8-1:0] s_tkeep;
    logic            s_tvalid;
    logic            s_tlast;
    logic [1:0]      s_tuser;

    logic [3:0]      memq_space;
    logic [3:0]      netq_space;
    logic [3:0]      reqq_space;

    logic [DW-1:0]   q_wdata;
    logic [DW/8-1:0] q_wkeep;
    logic            q_wlast;
    logic            q_wtrunc;
    logic            memq_write;
    logic            netq_write;
    logic            reqq_write;

    modport master (
        output s_tdata, s_tkeep, s_tvalid, s_tlast, s_tuser,
        output memq_space, netq_space, reqq_space,
        input  q_wdata, q_wkeep, q_wlast, q_wtrunc,
        input  memq_write, netq_write, reqq_write
    );

    modport slave (
        input  s_tdata, s_tkeep, s_tvalid, s_tlast, s_tuser,
        input  memq_space, netq_space, reqq_space,
        output q_wdata, q_wkeep, q_wlast, q_wtrunc,
        output memq_write, netq_write, reqq_write
    );

endinterface

// File: rtl/buf_demux_rx.sv
// Steers received frames into the memory, network or request queue by class,
// with whole-frame admission, mid-frame truncation, drop counting and XOFF.
module buf_demux_rx
    import buf_demux_rx_pkg::*;
#(
    parameter int THRES = THRES_DEFAULT,
    parameter int DW    = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    buf_demux_rx_if.slave  bus,
    output logic [15:0]    drop_cnt,
    output logic           xoff,
    output logic           busy
);

    localparam logic [3:0] THRES_L  = 4'(THRES);
    localparam logic [3:0] TRUNC_LIM = 4'd2;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_cls;
    logic [1:0]      w_cls_nxt;

    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_wkeep;
    logic            r_wlast;
    logic            r_wtrunc;
    logic            r_wr_mem;
    logic            r_wr_net;
    logic            r_wr_req;
    logic [15:0]     r_drop_cnt;
    logic            r_xoff;

    logic            w_write;
    logic [1:0]      w_wr_cls;
    logic            w_wlast;
    logic            w_wtrunc;
    logic            w_drop_inc;
    logic            w_admit;
    logic [3:0]      w_space_first;
    logic [3:0]      w_space_cls;

    function automatic logic [3:0] space_sel(
        input logic [1:0] c,
        input logic [3:0] mem_sp,
        input logic [3:0] net_sp,
        input logic [3:0] req_sp
    );
        case (c)
            CLS_MEM: space_sel = mem_sp;
            CLS_NET: space_sel = net_sp;
            CLS_REQ: space_sel = req_sp;
            default: space_sel = 4'd0;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_space_first = space_sel(bus.s_tuser, bus.memq_space, bus.netq_space, bus.reqq_space);
    assign w_space_cls   = space_sel(r_cls, bus.memq_space, bus.netq_space, bus.reqq_space);
    assign w_admit       = (bus.s_tuser != CLS_NONE) && (w_space_first >= THRES_L);

    always_comb begin
        w_state_nxt = r_state;
        w_cls_nxt   = r_cls;
        w_write     = 1'b0;
        w_wr_cls    = r_cls;
        w_wlast     = 1'b0;
        w_wtrunc    = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.s_tvalid) begin
                    if (w_admit) begin
                        w_write     = 1'b1;
                        w_wr_cls    = bus.s_tuser;
                        w_cls_nxt   = bus.s_tuser;
                        w_wlast     = bus.s_tlast;
                        w_state_nxt = bus.s_tlast ? ST_IDLE : ST_FWD;
                    end else begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = bus.s_tlast ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                if (bus.s_tvalid) begin
                    w_write = 1'b1;
                    if (bus.s_tlast) begin
                        w_wlast     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_space_cls <= TRUNC_LIM) begin
                        // Margin of 2 absorbs the one-cycle write latency
                        w_wlast     = 1'b1;
                        w_wtrunc    = 1'b1;
                        w_drop_inc  = 1'b1;
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (bus.s_tvalid && bus.s_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cls   <= CLS_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cls   <= w_cls_nxt;
        end
    end

    // Output stage: write bus, strobes, drop counter and XOFF hint
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdata    <= '0;
            r_wkeep    <= '0;
            r_wlast    <= 1'b0;
            r_wtrunc   <= 1'b0;
            r_wr_mem   <= 1'b0;
            r_wr_net   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_drop_cnt <= 16'd0;
            r_xoff     <= 1'b0;
        end else begin
            if (w_write) begin
                r_wdata <= bus.s_tdata;
                r_wkeep <= bus.s_tkeep;
            end
            r_wlast    <= w_wlast;
            r_wtrunc   <= w_wtrunc;
            r_wr_mem   <= w_write && (w_wr_cls == CLS_MEM);
            r_wr_net   <= w_write && (w_wr_cls == CLS_NET);
            r_wr_req   <= w_write && (w_wr_cls == CLS_REQ);
            if (w_drop_inc) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end
            r_xoff     <= (bus.netq_space < THRES_L);
        end
    end

    assign bus.q_wdata    = r_wdata;
    assign bus.q_wkeep    = r_wkeep;
    assign bus.q_wlast    = r_wlast;
    assign bus.q_wtrunc   = r_wtrunc;
    assign bus.memq_write = r_wr_mem;
    assign bus.netq_write = r_wr_net;
    assign bus.reqq_write = r_wr_req;
    assign drop_cnt       = r_drop_cnt;
    assign xoff           = r_xoff;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_buf_demux_rx.sv
// Randomized scoreboard bench for buf_demux_rx: a frame-level reference model
// predicts queue writes and status, a monitor compares what the DUT presents.
module tb_buf_demux_rx;
    import buf_demux_rx_pkg::*;

    localparam int DW  = 64;
    localparam int THR = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] drop_cnt;
    logic        xoff;
    logic        busy;

    buf_demux_rx_if #(.DW(DW)) bus ();

    buf_demux_rx #(.THRES(THR), .DW(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .drop_cnt (drop_cnt),
        .xoff     (xoff),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cls;
        logic [63:0] data;
        logic [7:0]  keep;
        bit          last;
        bit          trunc;
    } wr_t;

    typedef struct {
        bit          wr;
        logic [15:0] drop;
        bit          xoff;
        bit          busy;
    } st_t;

    wr_t wr_q[$];
    st_t st_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model: frame-level view of the receive stream
    bit          m_in_frame;
    bit          m_keep_frame;
    logic [1:0]  m_tgt;
    logic [15:0] m_drops;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] space_of(input logic [1:0] c);
        case (c)
            CLS_MEM: space_of = bus.memq_space;
            CLS_NET: space_of = bus.netq_space;
            CLS_REQ: space_of = bus.reqq_space;
            default: space_of = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] rsp();
        if ($urandom_range(0, 3) == 0) rsp = 4'($urandom_range(0, 4));
        else                           rsp = 4'($urandom_range(5, 15));
    endfunction

    function automatic void bump_drop();
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
    endfunction

    function automatic void model_reset();
        m_in_frame   = 1'b0;
        m_keep_frame = 1'b0;
        m_tgt        = CLS_NONE;
        m_drops      = 16'd0;
    endfunction

    task automatic drive(input bit v, input bit last, input logic [1:0] user,
                         input logic [3:0] ms, input logic [3:0] ns, input logic [3:0] rs);
        logic [63:0] d;
        logic [7:0]  k;
        bit          wrote;
        @(negedge clk);
        d = {$urandom, $urandom};
        k = 8'($urandom);
        bus.s_tdata    = d;
        bus.s_tkeep    = k;
        bus.s_tvalid   = v;
        bus.s_tlast    = last;
        bus.s_tuser    = user;
        bus.memq_space = ms;
        bus.netq_space = ns;
        bus.reqq_space = rs;
        wrote = 1'b0;
        if (v) begin
            if (!m_in_frame) begin
                if (user != CLS_NONE && space_of(user) >= 4'(THR)) begin
                    wr_q.push_back('{cls: user, data: d, keep: k, last: last, trunc: 1'b0});
                    wrote        = 1'b1;
                    m_keep_frame = 1'b1;
                    m_tgt        = user;
                end else begin
                    bump_drop();
                    m_keep_frame = 1'b0;
                end
                m_in_frame = !last;
            end else if (m_keep_frame) begin
                wrote = 1'b1;
                if (last) begin
                    wr_q.push_back('{cls: m_tgt, data: d, keep: k, last: 1'b1, trunc: 1'b0});
                    m_in_frame = 1'b0;
                end else if (space_of(m_tgt) <= 4'd2) begin
                    wr_q.push_back('{cls: m_tgt, data: d, keep: k, last: 1'b1, trunc: 1'b1});
                    bump_drop();
                    m_keep_frame = 1'b0;
                end else begin
                    wr_q.push_back('{cls: m_tgt, data: d, keep: k, last: 1'b0, trunc: 1'b0});
                end
            end else if (last) begin
                m_in_frame = 1'b0;
            end
        end
        st_q.push_back('{wr: wrote, drop: m_drops, xoff: (ns < 4'(THR)), busy: m_in_frame});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'($urandom), 4'd15, 4'd15, 4'd15);
    endtask

    task automatic send_frame(input logic [1:0] c, input int len);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 2'($urandom), rsp(), rsp(), rsp());
            drive(1'b1, (i == len - 1), (i == 0) ? c : 2'($urandom), rsp(), rsp(), rsp());
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, 64'({bus.memq_write, bus.netq_write, bus.reqq_write}), 64'd0);
        check({tag, "_wdata"}, bus.q_wdata, 64'd0);
        check({tag, "_wkeep"}, 64'(bus.q_wkeep), 64'd0);
        check({tag, "_wlast_trunc"}, 64'({bus.q_wlast, bus.q_wtrunc}), 64'd0);
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        check({tag, "_xoff_busy"}, 64'({xoff, busy}), 64'd0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        reset_n      = 1'b0;
        bus.s_tvalid = 1'b0;
        #1;
        check_all_zero("async_reset");
        wr_q.delete();
        st_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the queued predictions
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                int  nstb;
                wr_t e;
                st_t s;
                logic [1:0] acls;
                nstb = int'(bus.memq_write) + int'(bus.netq_write) + int'(bus.reqq_write);
                if (nstb > 0) begin
                    check("strobe_onehot", 64'(nstb), 64'd1);
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=%0d strobes required=none at %0t", nstb, $time);
                    end else begin
                        e = wr_q.pop_front();
                        acls = bus.memq_write ? CLS_MEM : (bus.netq_write ? CLS_NET : CLS_REQ);
                        check("wr_queue", 64'(acls), 64'(e.cls));
                        check("wr_data", bus.q_wdata, e.data);
                        check("wr_keep", 64'(bus.q_wkeep), 64'(e.keep));
                        check("wr_last", 64'(bus.q_wlast), 64'(e.last));
                        check("wr_trunc", 64'(bus.q_wtrunc), 64'(e.trunc));
                    end
                end
                if (st_q.size() > 0) begin
                    s = st_q.pop_front();
                    check("strobe_present", 64'(nstb != 0), 64'(s.wr));
                    check("drop_cnt", 64'(drop_cnt), 64'(s.drop));
                    check("xoff", 64'(xoff), 64'(s.xoff));
                    check("busy", 64'(busy), 64'(s.busy));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_tdata    = '0;
        bus.s_tkeep    = '0;
        bus.s_tvalid   = 1'b0;
        bus.s_tlast    = 1'b0;
        bus.s_tuser    = 2'b00;
        bus.memq_space = 4'd15;
        bus.netq_space = 4'd15;
        bus.reqq_space = 4'd15;
        model_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // NET 4-beat frame with plenty of space
        for (int i = 0; i < 4; i++) drive(1'b1, (i == 3), CLS_NET, 4'd15, 4'd8, 4'd15);
        idle(2);

        // MEM first beat refused at space 2: whole frame dropped
        drive(1'b1, 1'b0, CLS_MEM, 4'd2, 4'd8, 4'd15);
        drive(1'b1, 1'b0, CLS_MEM, 4'd2, 4'd8, 4'd15);
        drive(1'b0, 1'b0, CLS_NET, 4'd2, 4'd8, 4'd15);
        drive(1'b1, 1'b1, CLS_MEM, 4'd2, 4'd8, 4'd15);
        idle(2);

        // REQ 6-beat frame, space falling 5,4,3,2: truncated at the fourth beat
        begin
            logic [3:0] sp [6];
            sp = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd2, 4'd2};
            for (int i = 0; i < 6; i++) drive(1'b1, (i == 5), CLS_REQ, 4'd15, 4'd15, sp[i]);
        end
        idle(2);

        // Class 00 single beat then a MEM frame back-to-back
        drive(1'b1, 1'b1, CLS_NONE, 4'd8, 4'd8, 4'd8);
        for (int i = 0; i < 3; i++) drive(1'b1, (i == 2), CLS_MEM, 4'd8, 4'd8, 4'd8);

        // space<=2 together with tlast in FWD is a normal end
        drive(1'b1, 1'b0, CLS_NET, 4'd8, 4'd8, 4'd8);
        drive(1'b1, 1'b1, CLS_NET, 4'd8, 4'd1, 4'd8);

        // XOFF follows netq_space 5 -> 2 -> 3
        drive(1'b0, 1'b0, CLS_NONE, 4'd8, 4'd5, 4'd8);
        drive(1'b0, 1'b0, CLS_NONE, 4'd8, 4'd2, 4'd8);
        drive(1'b0, 1'b0, CLS_NONE, 4'd8, 4'd3, 4'd8);
        idle(1);

        // Reset mid-FWD; the following tail beat is handled as a first beat
        drive(1'b1, 1'b0, CLS_NET, 4'd8, 4'd8, 4'd8);
        drive(1'b1, 1'b0, CLS_NET, 4'd8, 4'd8, 4'd8);
        reset_mid();
        drive(1'b1, 1'b1, CLS_MEM, 4'd8, 4'd8, 4'd8);
        idle(2);

        // Randomized frames
        for (int f = 0; f < 400; f++) begin
            send_frame(2'($urandom), $urandom_range(1, 6));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        // Drop counter saturation
        for (int i = 0; i < 65540; i++) drive(1'b1, 1'b1, CLS_NONE, 4'd8, 4'd8, 4'd8);
        drive(1'b1, 1'b0, CLS_MEM, 4'd1, 4'd8, 4'd8);
        drive(1'b1, 1'b1, CLS_MEM, 4'd1, 4'd8, 4'd8);
        idle(3);

        @(posedge clk);
        #2;
        check("drop_cnt_saturated", 64'(drop_cnt), 64'hFFFF);
        check("write_queue_drained", 64'(wr_q.size()), 64'd0);
        check("status_queue_drained", 64'(st_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buf_demux_rx.md
# buf_demux_rx

Receive-side queue steering block, the RX counterpart of the TX buffer monitor/arbiter. It takes the decoded 64-bit AXI-Stream beat flow from the XGMII receive path and steers each frame into one of three receive queues: memory, network or request. The target queue comes from the class code carried in `tuser` on the frame's first beat. The block enforces per-queue admission (whole-frame drop), truncates frames when a queue runs out of space mid-frame, counts lost frames, and raises an XOFF hint toward the link partner.

## Interface
- `THRES`, 3: minimum free entries in the target queue required to admit a frame.
- `DW`, 64: data width; the keep width is `DW/8`.
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_tdata` in DW: receive beat data.
- `s_tkeep` in DW/8: byte enables.
- `s_tvalid` in 1: beat present. There is no ready signal; the XGMII path cannot stall.
- `s_tlast` in 1: last beat of the frame.
- `s_tuser` in 2: frame class, sampled on the first beat only. 01=REQ, 10=MEM, 11=NET, 00=invalid.
- `memq_space`, `netq_space`, `reqq_space` in 4 each: free entries in each queue.
- `q_wdata` out DW, `q_wkeep` out DW/8, `q_wlast` out 1: shared write bus to all three queues.
- `memq_write`, `netq_write`, `reqq_write` out 1: one-hot write strobes.
- `q_wtrunc` out 1: qualifies `q_wlast`; the frame was cut short.
- `drop_cnt` out 16: saturating count of dropped plus truncated frames.
- `xoff` out 1: registered; high while `netq_space < THRES`.
- `busy` out 1: FSM is not IDLE.

## Operation
- FSM states are IDLE, FWD and DROP. The latched class register `cls` holds the frame's class for its duration.
- IDLE, on `s_tvalid`: the beat is a first beat.
  - If class is 00 or target space < THRES, the frame is dropped and `drop_cnt` increments.
  - Otherwise the beat is written, `cls` is latched and the FSM goes to FWD.
  - A first beat carrying `s_tlast` is a single-beat frame: write (or drop) it and stay in IDLE.
  - A dropped frame goes to DROP unless the beat had `s_tlast`.
- FWD, on `s_tvalid`: write the beat to the `cls` queue.
  - If `s_tlast`, set `q_wlast`=1 and return to IDLE.
  - Else if target space ≤ 2, write the beat with `q_wlast`=1 and `q_wtrunc`=1, increment `drop_cnt`, and go to DROP.
  - Space is compared combinationally against the current input value. The margin of 2 covers the one-cycle write latency.
- DROP: discard all beats and write nothing. On a valid `s_tlast`, return to IDLE.
- Cycles with `s_tvalid`=0 are gaps. They never write, never advance state, and `tuser` is ignored on them.
- `drop_cnt` holds at 0xFFFF once saturated. At most one increment per frame.
- `s_tuser` on non-first beats is ignored.

## Timing
- All outputs are registered. A beat accepted at edge N appears on the write bus with its strobe during cycle N+1, so latency is one cycle.
- At most one write strobe is high per cycle. A strobe lasts exactly one cycle per written beat.
- Reset values are all zero: strobes, `q_w*`, `q_wtrunc`, `drop_cnt`, `busy`, FSM=IDLE, `cls`=00.
- `xoff` resets to 0 and is valid from the first edge after reset release.
- Reset asserted mid-frame: the FSM returns to IDLE immediately with no terminating `q_wlast`. The queues are reset alongside by the system.
- After reset release, the first valid beat is treated as a first beat even if it is a tail of an earlier frame.
- Simultaneous events in FWD:
  - `s_tlast` together with space ≤ 2 is a normal end: `q_wlast`=1, `q_wtrunc`=0, no count.
  - Admission failure together with `s_tlast` counts one drop and stays in IDLE.

## Structure
- A shared package holds:
  - the class codes REQ=2'b01, MEM=2'b10, NET=2'b11, which are the same encoding as the TX `sel`/`SEND_*` codes;
  - the FSM state enum;
  - the default THRES.
- A single module; no sub-module is needed. A space-select mux indexed by `cls` or `s_tuser` stays inline.

## Test plan
- NET 4-beat frame with `netq_space`=8: 4 `netq_write` pulses one cycle after each beat, `q_wlast` on the 4th, `drop_cnt`=0.
- MEM first beat with `memq_space`=2: frame dropped, no strobes, `drop_cnt`=1, FSM in DROP until `s_tlast`, then IDLE.
- REQ 6-beat frame with `reqq_space` falling 5,4,3,2: the beat seen at space 2 is written with `q_wlast`=1 and `q_wtrunc`=1, the remaining beats are discarded, `drop_cnt`=1.
- Class 00 single-beat frame, then a valid MEM frame back-to-back: the first is dropped (count 1) and the second is fully written with no gap cycle.
- `netq_space` steps 5→2→3: `xoff` goes 0→1→0, each change one cycle after the input.
- `reset_n` pulsed low mid-FWD: all outputs 0 asynchronously, FSM in IDLE; the next valid beat is handled as a new first beat.
- 65,536 back-to-back dropped frames: `drop_cnt` saturates at 0xFFFF.
